// File: rtl/uart_rx_fifo.sv
// Receive FIFO for a 16550-compatible UART: FWFT character store with per-entry
// error flags, LSR/IIR status, and optional character timeout (UART_RX_TIMEOUT_EN).
module uart_rx_fifo #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int TO_TICKS = 640
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pe_in,
  input  logic          fe_in,
  input  logic          bi_in,
  input  logic          pop,
  input  logic          fifo_en,
  input  logic          fifo_clr,
  input  logic          lsr_read,
  input  logic [1:0]    trig_lvl,
  input  logic          baud_pulse,
  output logic [7:0]    dout,
  output logic          dout_pe,
  output logic          dout_fe,
  output logic          dout_bi,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overrun,
  output logic          err_in_fifo,
  output logic          trigger,
  output logic          timeout
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  // Entry layout: {bi, fe, pe, data[7:0]}
  logic [10:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   errcnt;

  logic [10:0]   head;
  logic [AW:0]   eff_depth;
  logic [AW:0]   trig_count;
  logic          at_capacity;
  logic          in_err;
  logic          head_err;
  logic          do_push;
  logic          do_pop;
  logic          ovr_evt;
  logic [AW:0]   count_nxt;
  logic [AW:0]   errcnt_nxt;

  assign head      = mem[rd_ptr];
  assign in_err    = pe_in | fe_in | bi_in;
  assign head_err  = |head[10:8];
  assign eff_depth = fifo_en ? DEPTH_W : ONE_W;

  always_comb begin
    unique case (trig_lvl)
      2'b00:   trig_count = (AW+1)'(1);
      2'b01:   trig_count = (AW+1)'(4);
      2'b10:   trig_count = (AW+1)'(8);
      default: trig_count = (AW+1)'(14);
    endcase
  end

  // >= rather than == keeps a stale count from a mode switch without flush safe.
  assign at_capacity = (count >= eff_depth);

  // A push into a full FIFO still lands when the head is popped in the same cycle.
  always_comb begin
    do_pop     = pop  & (count != '0) & ~fifo_clr;
    do_push    = push & ~fifo_clr & (~at_capacity | pop);
    ovr_evt    = push & ~fifo_clr & at_capacity & ~pop;
    count_nxt  = count;
    errcnt_nxt = errcnt;
    if (fifo_clr) begin
      count_nxt  = '0;
      errcnt_nxt = '0;
    end else begin
      count_nxt = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if ((do_push & in_err) && !(do_pop & head_err))
        errcnt_nxt = errcnt + ONE_W;
      else if (!(do_push & in_err) && (do_pop & head_err))
        errcnt_nxt = errcnt - ONE_W;
    end
  end

  // NOTE: the storage array has no reset; empty masks its undefined contents.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= {bi_in, fe_in, pe_in, din};
  end

  // NOTE: all state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      errcnt      <= '0;
      overrun     <= 1'b0;
      empty       <= 1'b1;
      full        <= 1'b0;
      trigger     <= 1'b0;
      err_in_fifo <= 1'b0;
    end else begin
      if (fifo_clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      count       <= count_nxt;
      errcnt      <= errcnt_nxt;
      empty       <= (count_nxt == '0);
      full        <= (count_nxt == eff_depth);
      trigger     <= (count_nxt >= trig_count);
      err_in_fifo <= (errcnt_nxt != '0);
      if (ovr_evt)
        overrun <= 1'b1;
      else if (lsr_read)
        overrun <= 1'b0;
    end
  end

  assign dout    = empty ? 8'h00 : head[7:0];
  assign dout_pe = ~empty & head[8];
  assign dout_fe = ~empty & head[9];
  assign dout_bi = ~empty & head[10];

`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TO_TICKS + 1);
  localparam logic [TW-1:0] TO_W = TW'(TO_TICKS);

  logic [TW-1:0] to_cnt;
  logic [TW-1:0] to_cnt_nxt;
  logic          to_clear;

  always_comb begin
    to_clear   = do_push | do_pop | fifo_clr | (count_nxt == '0);
    to_cnt_nxt = to_cnt;
    if (to_clear)
      to_cnt_nxt = '0;
    else if (baud_pulse && (count != '0) && (to_cnt < TO_W))
      to_cnt_nxt = to_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      to_cnt  <= to_cnt_nxt;
      timeout <= (to_cnt_nxt >= TO_W);
    end
  end
`else
  logic unused_baud;
  assign unused_baud = baud_pulse;
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo; covers timeout when UART_RX_TIMEOUT_EN is defined.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       push, pop, fifo_en, fifo_clr, lsr_read, baud_pulse;
  logic [7:0] din;
  logic       pe_in, fe_in, bi_in;
  logic [1:0] trig_lvl;
  logic [7:0] dout;
  logic       dout_pe, dout_fe, dout_bi;
  logic       empty, full, overrun, err_in_fifo, trigger, timeout;
  logic [4:0] count;

  int n_cmp = 0;
  int n_err = 0;

  uart_rx_fifo #(.DEPTH(16), .AW(4), .TO_TICKS(640)) dut (
    .clk(clk), .rst(rst), .push(push), .din(din), .pe_in(pe_in), .fe_in(fe_in),
    .bi_in(bi_in), .pop(pop), .fifo_en(fifo_en), .fifo_clr(fifo_clr),
    .lsr_read(lsr_read), .trig_lvl(trig_lvl), .baud_pulse(baud_pulse),
    .dout(dout), .dout_pe(dout_pe), .dout_fe(dout_fe), .dout_bi(dout_bi),
    .empty(empty), .full(full), .count(count), .overrun(overrun),
    .err_in_fifo(err_in_fifo), .trigger(trigger), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then return the single-cycle strobes to idle 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; fifo_clr = 1'b0; lsr_read = 1'b0; baud_pulse = 1'b0;
    pe_in = 1'b0; fe_in = 1'b0; bi_in = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    push = 1'b1; din = d;
    tick();
  endtask

  task automatic rd();
    pop = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b0; push = 0; pop = 0; fifo_en = 1; fifo_clr = 0; lsr_read = 0;
    baud_pulse = 0; din = 0; pe_in = 0; fe_in = 0; bi_in = 0; trig_lvl = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overrun", overrun, 0);
    check("rst_err", err_in_fifo, 0);
    check("rst_trigger", trigger, 0);
    check("rst_timeout", timeout, 0);
    check("rst_dout", dout, 8'h00);
    @(negedge clk) rst = 1'b1;
    tick();

    // Basic FWFT ordering
    wr(8'h41); check("push1_empty", empty, 0); check("push1_dout", dout, 8'h41);
    wr(8'h42); wr(8'h43);
    check("abc_count", count, 3);
    check("abc_head", dout, 8'h41);
    rd(); check("pop1_dout", dout, 8'h42);
    rd(); check("pop2_dout", dout, 8'h43);
    rd(); check("pop3_empty", empty, 1); check("pop3_dout", dout, 8'h00);
    rd(); check("pop_empty_ignored", count, 0);

    // Trigger level 8
    trig_lvl = 2'b10;
    for (int i = 0; i < 7; i++) wr(8'(i));
    check("trig_7", trigger, 0);
    wr(8'h07); check("trig_8", trigger, 1);
    rd(); check("trig_pop", trigger, 0); check("trig_pop_count", count, 7);
    fifo_clr = 1'b1; tick();
    check("clr_count", count, 0); check("clr_empty", empty, 1);

    // Fill to 16 and overflow
    for (int i = 0; i < 15; i++) wr(8'h10 + 8'(i));
    check("fill15_full", full, 0);
    wr(8'h1F); check("fill16_full", full, 1); check("fill16_count", count, 16);
    check("fill16_ovr", overrun, 0);
    wr(8'hEE);
    check("ovf_overrun", overrun, 1); check("ovf_count", count, 16);
    check("ovf_head", dout, 8'h10);
    lsr_read = 1'b1; tick(); check("lsr_clears", overrun, 0);
    push = 1'b1; din = 8'hC5; pop = 1'b1; tick();
    check("full_pushpop_head", dout, 8'h11); check("full_pushpop_count", count, 16);
    check("full_pushpop_ovr", overrun, 0);
    fifo_clr = 1'b1; tick();

    // Error-in-FIFO tracking
    wr(8'h11);
    fe_in = 1'b1; wr(8'h55);
    wr(8'h33);
    check("err_set", err_in_fifo, 1); check("err_head_fe", dout_fe, 0);
    rd(); check("err_still", err_in_fifo, 1); check("err_head55", dout, 8'h55);
    check("err_head55_fe", dout_fe, 1);
    rd(); check("err_cleared", err_in_fifo, 0); check("err_head33", dout, 8'h33);
    rd(); check("err_empty", empty, 1);

    // 16450 mode
    fifo_en = 1'b0;
    wr(8'hA1); wr(8'hA2);
    check("m450_count", count, 1); check("m450_full", full, 1);
    check("m450_ovr", overrun, 1); check("m450_head", dout, 8'hA1);
    push = 1'b1; din = 8'hB0; lsr_read = 1'b1; tick();
    check("ovr_set_wins", overrun, 1);
    lsr_read = 1'b1; tick(); check("m450_lsr", overrun, 0);
    push = 1'b1; din = 8'hA3; pop = 1'b1; tick();
    check("m450_pushpop_head", dout, 8'hA3); check("m450_pushpop_count", count, 1);
    check("m450_pushpop_ovr", overrun, 0);
    rd(); check("m450_empty", empty, 1);
    push = 1'b1; din = 8'h5A; pop = 1'b1; tick();
    check("empty_pushpop_count", count, 1); check("empty_pushpop_head", dout, 8'h5A);
    push = 1'b1; din = 8'h66; fifo_clr = 1'b1; tick();
    check("clr_push_count", count, 0); check("clr_push_ovr", overrun, 0);
    check("clr_push_empty", empty, 1);

    // Character timeout
    fifo_en = 1'b1;
    wr(8'h77);
    for (int i = 0; i < 639; i++) begin baud_pulse = 1'b1; tick(); end
    check("to_639", timeout, 0);
    baud_pulse = 1'b1; tick();
`ifdef UART_RX_TIMEOUT_EN
    check("to_640", timeout, 1);
`else
    check("to_tied_off", timeout, 0);
`endif
    rd(); check("to_pop_clear", timeout, 0); check("to_pop_empty", empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
